// File: rtl/game_pkg.sv
// Shared definitions for the VGA game: raster widths, frame timing and jump states.
// Imported by the character-motion logic and by the VGA controller.
package game_pkg;

   localparam int COL_W     = 12;
   localparam int ROW_W     = 11;
   localparam int VER_FIELD = 1023;
   localparam int VER_TOTAL = 1065;

   typedef enum logic [1:0] {
      GROUNDED = 2'd0,
      ASCEND   = 2'd1,
      DESCEND  = 2'd2,
      LAND     = 2'd3
   } jump_state_t;

endpackage

// File: rtl/frame_key_sampler.sv
// Synchronises the jump button and detects a new press, sampled once per frame.
// Sampling at frame rate debounces the key and prevents auto-repeat while held.
module frame_key_sampler (
   input  logic clock,
   input  logic reset,
   input  logic jump_key,
   input  logic frame_tick,
   output logic jump_edge
);

   logic key_meta;
   logic key_s;
   logic key_prev;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         key_meta <= 1'b0;
         key_s    <= 1'b0;
         key_prev <= 1'b0;
      end else begin
         key_meta <= jump_key;
         key_s    <= key_meta;
         if (frame_tick)
            key_prev <= key_s;
      end
   end

   assign jump_edge = frame_tick & key_s & ~key_prev;

endmodule

// File: rtl/jump_controller.sv
// Vertical-motion sequencer for the player character: one position update per frame,
// applied at the start of vertical blanking so the renderer never sees a mid-frame move.
module jump_controller
   import game_pkg::*;
#(
   parameter int TICK_ROW = 1024,
   parameter int GROUND_Y = 800,
   parameter int MIN_Y    = 0,
   parameter int JUMP_VEL = 24,
   parameter int GRAVITY  = 1,
   parameter int MAX_FALL = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [COL_W-1:0] display_col,
   input  logic [ROW_W-1:0] display_row,
   input  logic             jump_key,
   output logic [ROW_W-1:0] char_y,
   output logic             airborne,
   output logic             frame_tick,
   output logic [1:0]       state
);

   localparam int VEL_W = 6;
   localparam int SUM_W = ROW_W + 1;

   localparam logic [ROW_W-1:0] TICK_ROW_V = ROW_W'(TICK_ROW);
   localparam logic [ROW_W-1:0] GROUND_V   = ROW_W'(GROUND_Y);
   localparam logic [ROW_W-1:0] MIN_V      = ROW_W'(MIN_Y);
   localparam logic [SUM_W-1:0] GROUND_S   = SUM_W'(GROUND_Y);
   localparam logic [SUM_W-1:0] MIN_S      = SUM_W'(MIN_Y);
   localparam logic [VEL_W-1:0] JUMP_V     = VEL_W'(JUMP_VEL);
   localparam logic [VEL_W-1:0] GRAV_V     = VEL_W'(GRAVITY);
   localparam logic [VEL_W-1:0] MAX_FALL_V = VEL_W'(MAX_FALL);

   jump_state_t      state_q;
   jump_state_t      state_nxt;
   logic [VEL_W-1:0] vel_q;
   logic [VEL_W-1:0] vel_nxt;
   logic [VEL_W-1:0] fall_vel;
   logic [VEL_W:0]   vel_inc;
   logic [ROW_W-1:0] y_nxt;
   logic [ROW_W-1:0] rise_y;
   logic [SUM_W-1:0] y_ext;
   logic [SUM_W-1:0] vel_ext;
   logic [SUM_W-1:0] fall_y;
   logic             jump_edge;

   frame_key_sampler u_key_sampler (
      .clock      (clock),
      .reset      (reset),
      .jump_key   (jump_key),
      .frame_tick (frame_tick),
      .jump_edge  (jump_edge)
   );

   // Stage 0: frame tick from raster position
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         frame_tick <= 1'b0;
      else
         frame_tick <= (display_row == TICK_ROW_V) && (display_col == '0);
   end

   // Sums carry one extra bit so an overshoot past the ground is visible before clamping.
   always_comb begin
      y_ext     = {1'b0, char_y};
      vel_ext   = SUM_W'(vel_q);
      rise_y    = char_y - ROW_W'(vel_q);
      vel_inc   = {1'b0, vel_q} + {1'b0, GRAV_V};
      fall_vel  = (vel_inc > {1'b0, MAX_FALL_V}) ? MAX_FALL_V : vel_inc[VEL_W-1:0];
      fall_y    = y_ext + SUM_W'(fall_vel);
      state_nxt = state_q;
      vel_nxt   = vel_q;
      y_nxt     = char_y;
      if (frame_tick) begin
         case (state_q)
            GROUNDED: begin
               y_nxt = GROUND_V;
               if (jump_edge) begin
                  state_nxt = ASCEND;
                  vel_nxt   = JUMP_V;
               end
            end
            ASCEND: begin
               y_nxt = (y_ext >= vel_ext + MIN_S) ? rise_y : MIN_V;
               if (vel_q > GRAV_V) begin
                  vel_nxt = vel_q - GRAV_V;
               end else begin
                  vel_nxt   = '0;
                  state_nxt = DESCEND;
               end
            end
            DESCEND: begin
               if (fall_y >= GROUND_S) begin
                  y_nxt     = GROUND_V;
                  vel_nxt   = '0;
                  state_nxt = LAND;
               end else begin
                  y_nxt   = fall_y[ROW_W-1:0];
                  vel_nxt = fall_vel;
               end
            end
            LAND:    state_nxt = GROUNDED;
            default: state_nxt = GROUNDED;
         endcase
      end
   end

   // Stage 1: motion state, applied on the tick edge
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= GROUNDED;
         char_y   <= GROUND_V;
         vel_q    <= '0;
         airborne <= 1'b0;
      end else begin
         state_q  <= state_nxt;
         char_y   <= y_nxt;
         vel_q    <= vel_nxt;
         airborne <= (state_nxt == ASCEND) || (state_nxt == DESCEND);
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_jump_controller.sv
// Scoreboard bench for jump_controller: a compressed 16-cycle "frame" drives the tick position,
// expected motion is queued per tick and compared once the update has landed.
module tb_jump_controller;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [11:0] display_col = '0;
   logic [10:0] display_row = '0;
   logic        jump_key = 1'b0;

   logic [10:0] char_y0, char_y1;
   logic        airborne0, airborne1;
   logic        frame_tick0, frame_tick1;
   logic [1:0]  state0, state1;

   typedef struct {
      int y0;
      int st0;
      int y1;
      int st1;
   } exp_t;

   exp_t sb_q[$];

   int n_checks   = 0;
   int n_fail     = 0;
   int tick_count = 0;

   int  gy[2] = '{800, 100};
   int  m_st[2];
   int  m_y[2];
   int  m_v[2];
   bit  m_kprev;

   jump_controller u_dut (
      .clock       (clock),
      .reset       (reset),
      .display_col (display_col),
      .display_row (display_row),
      .jump_key    (jump_key),
      .char_y      (char_y0),
      .airborne    (airborne0),
      .frame_tick  (frame_tick0),
      .state       (state0)
   );

   jump_controller #(.GROUND_Y(100)) u_dut_low (
      .clock       (clock),
      .reset       (reset),
      .display_col (display_col),
      .display_row (display_row),
      .jump_key    (jump_key),
      .char_y      (char_y1),
      .airborne    (airborne1),
      .frame_tick  (frame_tick1),
      .state       (state1)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_st[i] = 0;
         m_y[i]  = gy[i];
         m_v[i]  = 0;
      end
      m_kprev = 1'b0;
   endfunction

   function automatic void model_step(input bit key);
      bit edge_k;
      int nv;
      edge_k  = key && !m_kprev;
      m_kprev = key;
      for (int i = 0; i < 2; i++) begin
         case (m_st[i])
            0: begin
               m_y[i] = gy[i];
               if (edge_k) begin
                  m_st[i] = 1;
                  m_v[i]  = 24;
               end
            end
            1: begin
               m_y[i] = (m_y[i] - m_v[i] < 0) ? 0 : m_y[i] - m_v[i];
               if (m_v[i] > 1) m_v[i] = m_v[i] - 1;
               else begin
                  m_v[i]  = 0;
                  m_st[i] = 2;
               end
            end
            2: begin
               nv = (m_v[i] + 1 > 32) ? 32 : m_v[i] + 1;
               if (m_y[i] + nv >= gy[i]) begin
                  m_y[i]  = gy[i];
                  m_v[i]  = 0;
                  m_st[i] = 3;
               end else begin
                  m_y[i] = m_y[i] + nv;
                  m_v[i] = nv;
               end
            end
            default: m_st[i] = 0;
         endcase
      end
   endfunction

   // One compressed frame; the last cycle presents the tick position.
   task automatic run_frame(input bit key_lvl, input bit pulse);
      exp_t e;
      for (int c = 0; c < 16; c++) begin
         @(negedge clock);
         jump_key = pulse ? (c >= 1 && c <= 10) : key_lvl;
         if (c == 15) begin
            display_row = 11'd1024;
            display_col = 12'd0;
            model_step(pulse ? 1'b0 : key_lvl);
            e.y0  = m_y[0];
            e.st0 = m_st[0];
            e.y1  = m_y[1];
            e.st1 = m_st[1];
            sb_q.push_back(e);
         end else begin
            display_row = (c % 2 == 1) ? 11'd1024 : 11'(c * 60);
            display_col = (c % 2 == 1) ? 12'(c) : 12'd0;
         end
      end
   endtask

   task automatic run_frames(input int n, input bit key_lvl);
      for (int k = 0; k < n; k++) run_frame(key_lvl, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clock);
         display_row = 11'd0;
         display_col = 12'd5;
      end
   endtask

   task automatic check_pos(input string tag, input int y0, input int st0, input int y1, input int st1);
      check({tag, "_y0"}, char_y0, y0);
      check({tag, "_state0"}, state0, st0);
      check({tag, "_air0"}, airborne0, (st0 == 1 || st0 == 2));
      check({tag, "_y1"}, char_y1, y1);
      check({tag, "_state1"}, state1, st1);
   endtask

   task automatic apply_reset(input string tag);
      @(negedge clock);
      #1 reset = 1'b1;
      #1;
      check({tag, "_y0"}, char_y0, 800);
      check({tag, "_state0"}, state0, 0);
      check({tag, "_air0"}, airborne0, 0);
      check({tag, "_tick0"}, frame_tick0, 0);
      check({tag, "_y1"}, char_y1, 100);
      check({tag, "_air1"}, airborne1, 0);
      model_reset();
      sb_q.delete();
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   // Monitor: the update is visible one cycle after the tick pulse is seen.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (frame_tick0) begin
            tick_count++;
            check("tick_pair", frame_tick1, 1);
            @(negedge clock);
            check("tick_single", frame_tick0, 0);
            if (sb_q.size() == 0) begin
               check("unexpected_tick", 1, 0);
            end else begin
               e = sb_q.pop_front();
               check("sb_y0", char_y0, e.y0);
               check("sb_state0", state0, e.st0);
               check("sb_air0", airborne0, (e.st0 == 1 || e.st0 == 2));
               check("sb_y1", char_y1, e.y1);
               check("sb_state1", state1, e.st1);
               check("sb_air1", airborne1, (e.st1 == 1 || e.st1 == 2));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();
      apply_reset("reset");

      run_frames(3, 1'b0);
      idle(3);
      check("tick_count", tick_count, 3);
      check_pos("idle", 800, 0, 100, 0);

      // single press: apex after 24 ascend ticks, ceiling clamp on the low-ground unit
      run_frame(1'b1, 1'b0);
      run_frames(24, 1'b0);
      idle(3);
      check_pos("apex", 500, 2, 0, 2);
      run_frames(25, 1'b0);
      idle(3);
      check_pos("landed", 800, 0, 100, 0);

      // held key: exactly one jump
      run_frames(100, 1'b1);
      idle(3);
      check_pos("held", 800, 0, 100, 0);

      // re-press after release, with a press mid-ascent that must be ignored
      run_frames(2, 1'b0);
      run_frame(1'b1, 1'b0);
      run_frames(10, 1'b0);
      run_frames(2, 1'b1);
      run_frames(12, 1'b0);
      idle(3);
      check_pos("apex2", 500, 2, 0, 2);

      apply_reset("reset_apex");

      // key pulses that never reach a tick
      for (int k = 0; k < 3; k++) run_frame(1'b0, 1'b1);
      idle(3);
      check_pos("pulse", 800, 0, 100, 0);

      check("sb_drain", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
